spi_slave_rx: RTL

- Receive-side companion to the team's 12-bit SPI master.
- Oversamples the master's sclk/cs/mosi in the system clk domain, deserialises 12-bit LSB-first frames, checks frame length, and buffers received words in a small FIFO.
- Words are presented to downstream logic over a valid/ready interface.
- Sits directly downstream of the SPI master in the loopback/verification environment.

---
 rtl/spi_slave_rx_if.sv | 29 ++
 rtl/spi_slave_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_if.sv
// Bus bundle between the SPI line / word consumer and the spi_slave_rx receiver.
interface spi_slave_rx_if #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              sclk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              frame_err;
    logic              overflow;
    logic [LVL_W-1:0]  fifo_level;

    // Environment side: drives the SPI wires and consumes words.
    modport master (
        output sclk, cs, mosi, dout_ready,
        input  dout, dout_valid, frame_err, overflow, fifo_level
    );

    // Receiver side.
    modport slave (
        input  sclk, cs, mosi, dout_ready,
        output dout, dout_valid, frame_err, overflow, fifo_level
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI receiver: oversamples sclk/cs/mosi, deserialises LSB-first frames,
// checks frame length and buffers good words in a small FIFO.
module spi_slave_rx #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_rx_if.slave  bus
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned CW    = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DUMMY, SHIFT, CHECK} state_t;

    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic [SYNC_STAGES:0]   vld_q;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_fall_c, cs_fall_c, cs_rise_c;

    state_t                 state, state_nx;
    logic [DATA_W-1:0]      shreg, shreg_nx;
    logic [CW-1:0]          bitcnt, bitcnt_nx;
    logic                   long_f, long_nx;
    logic                   good_c, err_c;

    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr, rd_nx_c;
    logic [LVL_W-1:0]       level_q, level_nx_c;
    logic [DATA_W-1:0]      dout_q, head_c;
    logic                   valid_q, err_q, ovf_q;
    logic                   pop_c, push_c, full_c, ovf_c;

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign cs_s   = cs_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // vld_q marks when cs_d holds a real sample rather than its reset value,
    // so a cs held low across reset is not mistaken for a fresh falling edge.
    assign sclk_fall_c = sclk_d & ~sclk_s;
    assign cs_fall_c   = vld_q[SYNC_STAGES] & cs_d & ~cs_s;
    assign cs_rise_c   = vld_q[SYNC_STAGES] & ~cs_d & cs_s;

    // Input synchronisers plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
            vld_q  <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], bus.cs};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Frame FSM state and deserialiser registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            long_f <= 1'b0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            bitcnt <= bitcnt_nx;
            long_f <= long_nx;
        end
    end

    // Frame FSM next state, shifting and length verdict.
    always_comb begin
        state_nx  = state;
        shreg_nx  = shreg;
        bitcnt_nx = bitcnt;
        long_nx   = long_f;
        good_c    = 1'b0;
        err_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall_c) begin
                    state_nx  = DUMMY;
                    shreg_nx  = '0;
                    bitcnt_nx = '0;
                    long_nx   = 1'b0;
                end
            end
            DUMMY: begin
                if (cs_rise_c) begin
                    state_nx = CHECK;
                end else if (sclk_fall_c) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise_c) begin
                    state_nx = CHECK;
                end else if (sclk_fall_c) begin
                    if (bitcnt < CW'(DATA_W)) begin
                        shreg_nx  = shreg | (DATA_W'(mosi_s) << bitcnt);
                        bitcnt_nx = bitcnt + CW'(1);
                    end else begin
                        long_nx = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_nx = IDLE;
                if (bitcnt == CW'(DATA_W) && !long_f) begin
                    good_c = 1'b1;
                end else begin
                    err_c = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FIFO control: push/pop decisions, next read pointer, next level and head word.
    always_comb begin
        pop_c      = valid_q & bus.dout_ready;
        full_c     = (level_q == LVL_W'(FIFO_DEPTH));
        push_c     = good_c & (~full_c | pop_c);
        ovf_c      = good_c & full_c & ~pop_c;
        rd_nx_c    = rd_ptr + AW'(pop_c);
        level_nx_c = level_q;
        if (push_c && !pop_c) begin
            level_nx_c = level_q + LVL_W'(1);
        end else if (pop_c && !push_c) begin
            level_nx_c = level_q - LVL_W'(1);
        end
        // A word written into a FIFO that is empty after this cycle's pop is the new head.
        head_c = (push_c && wr_ptr == rd_nx_c) ? shreg : mem[rd_nx_c];
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers, level and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rd_ptr  <= rd_nx_c;
            wr_ptr  <= wr_ptr + AW'(push_c);
            level_q <= level_nx_c;
            dout_q  <= head_c;
            valid_q <= (level_nx_c != '0);
            err_q   <= err_c;
            ovf_q   <= ovf_c;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_level = level_q;
endmodule
